// File: rtl/peripheral_mem2axi4_pkg.sv
// Shared types and AXI4 constants for the memory-to-AXI4 master bridge.
package peripheral_mem2axi4_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WADDR_DATA,
        WRESP,
        RADDR,
        RDATA
    } state_t;

    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [1:0] RESP_OKAY     = 2'b00;
    localparam logic [1:0] RESP_EXOKAY   = 2'b01;
    localparam logic [1:0] RESP_SLVERR   = 2'b10;
    localparam logic [1:0] RESP_DECERR   = 2'b11;
    localparam logic [3:0] CACHE_DEFAULT = 4'b0011;

endpackage

// File: rtl/peripheral_mem2axi4_master.sv
// Bridge from the native memory request interface to a single-beat AXI4 master.
// One transaction outstanding at a time.
// Optional feature: define MEM2AXI4_ERR_EN to report SLVERR/DECERR and missing
// r_last on err_o; otherwise err_o is tied low.
module peripheral_mem2axi4_master
    import peripheral_mem2axi4_pkg::*;
#(
    parameter int unsigned AXI_ID_WIDTH   = 10,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 16,
    parameter int unsigned AXI_STRB_WIDTH = 8,
    parameter int unsigned AXI_USER_WIDTH = 10
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        req_i,
    input  logic                        we_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] be_i,
    input  logic [AXI_DATA_WIDTH-1:0]   data_i,
    output logic                        gnt_o,
    output logic                        rvalid_o,
    output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
    output logic                        err_o,
    output logic [AXI_ID_WIDTH-1:0]     axi_aw_id_o,
    output logic [AXI_ADDR_WIDTH-1:0]   axi_aw_addr_o,
    output logic [7:0]                  axi_aw_len_o,
    output logic [2:0]                  axi_aw_size_o,
    output logic [1:0]                  axi_aw_burst_o,
    output logic                        axi_aw_lock_o,
    output logic [3:0]                  axi_aw_cache_o,
    output logic [2:0]                  axi_aw_prot_o,
    output logic [3:0]                  axi_aw_qos_o,
    output logic [3:0]                  axi_aw_region_o,
    output logic [AXI_USER_WIDTH-1:0]   axi_aw_user_o,
    output logic                        axi_aw_valid_o,
    input  logic                        axi_aw_ready_i,
    output logic [AXI_DATA_WIDTH-1:0]   axi_w_data_o,
    output logic [AXI_STRB_WIDTH-1:0]   axi_w_strb_o,
    output logic                        axi_w_last_o,
    output logic [AXI_USER_WIDTH-1:0]   axi_w_user_o,
    output logic                        axi_w_valid_o,
    input  logic                        axi_w_ready_i,
    input  logic [AXI_ID_WIDTH-1:0]     axi_b_id_i,
    input  logic [1:0]                  axi_b_resp_i,
    input  logic [AXI_USER_WIDTH-1:0]   axi_b_user_i,
    input  logic                        axi_b_valid_i,
    output logic                        axi_b_ready_o,
    output logic [AXI_ID_WIDTH-1:0]     axi_ar_id_o,
    output logic [AXI_ADDR_WIDTH-1:0]   axi_ar_addr_o,
    output logic [7:0]                  axi_ar_len_o,
    output logic [2:0]                  axi_ar_size_o,
    output logic [1:0]                  axi_ar_burst_o,
    output logic                        axi_ar_lock_o,
    output logic [3:0]                  axi_ar_cache_o,
    output logic [2:0]                  axi_ar_prot_o,
    output logic [3:0]                  axi_ar_qos_o,
    output logic [3:0]                  axi_ar_region_o,
    output logic [AXI_USER_WIDTH-1:0]   axi_ar_user_o,
    output logic                        axi_ar_valid_o,
    input  logic                        axi_ar_ready_i,
    input  logic [AXI_ID_WIDTH-1:0]     axi_r_id_i,
    input  logic [AXI_DATA_WIDTH-1:0]   axi_r_data_i,
    input  logic [1:0]                  axi_r_resp_i,
    input  logic                        axi_r_last_i,
    input  logic [AXI_USER_WIDTH-1:0]   axi_r_user_i,
    input  logic                        axi_r_valid_i,
    output logic                        axi_r_ready_o
);

    localparam int unsigned BE_WIDTH  = AXI_DATA_WIDTH / 8;
    localparam logic [2:0]  AXI_SIZE  = 3'($clog2(BE_WIDTH));

    state_t                      state;
    state_t                      state_next;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [BE_WIDTH-1:0]         be_q;
    logic [AXI_DATA_WIDTH-1:0]   data_q;
    logic                        aw_done;
    logic                        w_done;
    logic                        rvalid_q;
    logic [AXI_DATA_WIDTH-1:0]   rdata_q;
    logic                        attr_live;
    logic                        gnt;
    logic                        aw_valid;
    logic                        w_valid;
    logic                        b_ready;
    logic                        ar_valid;
    logic                        r_ready;

`ifdef MEM2AXI4_ERR_EN
    logic err_q;
    logic err_acc;
    logic beat_err;
    assign beat_err = (axi_r_resp_i != RESP_OKAY) || !axi_r_last_i;
    assign err_o    = err_q;
`else
    assign err_o    = 1'b0;
`endif

    // Next-state and channel handshake controls
    always_comb begin
        state_next = state;
        gnt        = 1'b0;
        aw_valid   = 1'b0;
        w_valid    = 1'b0;
        b_ready    = 1'b0;
        ar_valid   = 1'b0;
        r_ready    = 1'b0;
        case (state)
            IDLE: begin
                gnt = req_i;
                if (req_i) state_next = we_i ? WADDR_DATA : RADDR;
            end
            WADDR_DATA: begin
                aw_valid = !aw_done;
                w_valid  = !w_done;
                if ((aw_done || axi_aw_ready_i) && (w_done || axi_w_ready_i))
                    state_next = WRESP;
            end
            WRESP: begin
                b_ready = 1'b1;
                if (axi_b_valid_i) state_next = IDLE;
            end
            RADDR: begin
                ar_valid = 1'b1;
                if (axi_ar_ready_i) state_next = RDATA;
            end
            RDATA: begin
                r_ready = 1'b1;
                if (axi_r_valid_i && axi_r_last_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State, request register, per-channel done flags and completion pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            addr_q    <= '0;
            be_q      <= '0;
            data_q    <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            attr_live <= 1'b0;
`ifdef MEM2AXI4_ERR_EN
            err_q     <= 1'b0;
            err_acc   <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            attr_live <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
`ifdef MEM2AXI4_ERR_EN
            err_q     <= 1'b0;
`endif
            if (state == IDLE && req_i) begin
                addr_q  <= addr_i;
                be_q    <= be_i;
                data_q  <= data_i;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
`ifdef MEM2AXI4_ERR_EN
                err_acc <= 1'b0;
`endif
            end
            if (aw_valid && axi_aw_ready_i) aw_done <= 1'b1;
            if (w_valid && axi_w_ready_i)   w_done  <= 1'b1;
            if (b_ready && axi_b_valid_i) begin
                rvalid_q <= 1'b1;
`ifdef MEM2AXI4_ERR_EN
                err_q    <= (axi_b_resp_i != RESP_OKAY);
`endif
            end
            if (r_ready && axi_r_valid_i) begin
`ifdef MEM2AXI4_ERR_EN
                err_acc <= err_acc | beat_err;
`endif
                if (axi_r_last_i) begin
                    rvalid_q <= 1'b1;
                    rdata_q  <= axi_r_data_i;
`ifdef MEM2AXI4_ERR_EN
                    err_q    <= err_acc | beat_err;
`endif
                end
            end
        end
    end

    assign gnt_o    = gnt & rst_ni;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;

    // Fixed attributes are gated by attr_live so every output reads 0 in reset
    assign axi_aw_id_o     = '0;
    assign axi_aw_addr_o   = addr_q;
    assign axi_aw_len_o    = '0;
    assign axi_aw_size_o   = attr_live ? AXI_SIZE : 3'd0;
    assign axi_aw_burst_o  = attr_live ? BURST_INCR : 2'd0;
    assign axi_aw_lock_o   = 1'b0;
    assign axi_aw_cache_o  = attr_live ? CACHE_DEFAULT : 4'd0;
    assign axi_aw_prot_o   = '0;
    assign axi_aw_qos_o    = '0;
    assign axi_aw_region_o = '0;
    assign axi_aw_user_o   = '0;
    assign axi_aw_valid_o  = aw_valid;

    assign axi_w_data_o    = data_q;
    assign axi_w_strb_o    = AXI_STRB_WIDTH'(be_q);
    assign axi_w_last_o    = attr_live;
    assign axi_w_user_o    = '0;
    assign axi_w_valid_o   = w_valid;

    assign axi_b_ready_o   = b_ready;

    assign axi_ar_id_o     = '0;
    assign axi_ar_addr_o   = addr_q;
    assign axi_ar_len_o    = '0;
    assign axi_ar_size_o   = attr_live ? AXI_SIZE : 3'd0;
    assign axi_ar_burst_o  = attr_live ? BURST_INCR : 2'd0;
    assign axi_ar_lock_o   = 1'b0;
    assign axi_ar_cache_o  = attr_live ? CACHE_DEFAULT : 4'd0;
    assign axi_ar_prot_o   = '0;
    assign axi_ar_qos_o    = '0;
    assign axi_ar_region_o = '0;
    assign axi_ar_user_o   = '0;
    assign axi_ar_valid_o  = ar_valid;

    assign axi_r_ready_o   = r_ready;

    // Response sideband fields carry nothing this block needs
    logic unused_inputs;
`ifdef MEM2AXI4_ERR_EN
    assign unused_inputs = ^{axi_b_id_i, axi_b_user_i, axi_r_id_i, axi_r_user_i};
`else
    assign unused_inputs = ^{axi_b_id_i, axi_b_user_i, axi_r_id_i, axi_r_user_i,
                             axi_b_resp_i, axi_r_resp_i};
`endif

endmodule

// File: tb/tb_peripheral_mem2axi4_master.sv
// Self-checking bench for peripheral_mem2axi4_master: transaction-level model
// plus directed scenarios with literal expectations.
module tb_peripheral_mem2axi4_master;
    import peripheral_mem2axi4_pkg::*;

    localparam int unsigned IDW = 10;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 16;
    localparam int unsigned SW  = 8;
    localparam int unsigned UW  = 10;
    localparam int unsigned BW  = DW / 8;

`ifdef MEM2AXI4_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic rst_ni;
    logic req_i, we_i;
    logic [AW-1:0] addr_i;
    logic [BW-1:0] be_i;
    logic [DW-1:0] data_i;
    logic gnt_o, rvalid_o, err_o;
    logic [DW-1:0] rdata_o;
    logic [IDW-1:0] axi_aw_id_o, axi_ar_id_o, axi_b_id_i, axi_r_id_i;
    logic [AW-1:0] axi_aw_addr_o, axi_ar_addr_o;
    logic [7:0] axi_aw_len_o, axi_ar_len_o;
    logic [2:0] axi_aw_size_o, axi_ar_size_o, axi_aw_prot_o, axi_ar_prot_o;
    logic [1:0] axi_aw_burst_o, axi_ar_burst_o, axi_b_resp_i, axi_r_resp_i;
    logic axi_aw_lock_o, axi_ar_lock_o;
    logic [3:0] axi_aw_cache_o, axi_ar_cache_o, axi_aw_qos_o, axi_ar_qos_o;
    logic [3:0] axi_aw_region_o, axi_ar_region_o;
    logic [UW-1:0] axi_aw_user_o, axi_ar_user_o, axi_w_user_o, axi_b_user_i, axi_r_user_i;
    logic axi_aw_valid_o, axi_aw_ready_i, axi_w_valid_o, axi_w_ready_i, axi_w_last_o;
    logic [DW-1:0] axi_w_data_o, axi_r_data_i;
    logic [SW-1:0] axi_w_strb_o;
    logic axi_b_valid_i, axi_b_ready_o, axi_ar_valid_o, axi_ar_ready_i;
    logic axi_r_last_i, axi_r_valid_i, axi_r_ready_o;

    peripheral_mem2axi4_master #(
        .AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
        .AXI_STRB_WIDTH(SW), .AXI_USER_WIDTH(UW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i),
        .addr_i(addr_i), .be_i(be_i), .data_i(data_i), .gnt_o(gnt_o),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
        .axi_aw_id_o(axi_aw_id_o), .axi_aw_addr_o(axi_aw_addr_o), .axi_aw_len_o(axi_aw_len_o),
        .axi_aw_size_o(axi_aw_size_o), .axi_aw_burst_o(axi_aw_burst_o), .axi_aw_lock_o(axi_aw_lock_o),
        .axi_aw_cache_o(axi_aw_cache_o), .axi_aw_prot_o(axi_aw_prot_o), .axi_aw_qos_o(axi_aw_qos_o),
        .axi_aw_region_o(axi_aw_region_o), .axi_aw_user_o(axi_aw_user_o),
        .axi_aw_valid_o(axi_aw_valid_o), .axi_aw_ready_i(axi_aw_ready_i),
        .axi_w_data_o(axi_w_data_o), .axi_w_strb_o(axi_w_strb_o), .axi_w_last_o(axi_w_last_o),
        .axi_w_user_o(axi_w_user_o), .axi_w_valid_o(axi_w_valid_o), .axi_w_ready_i(axi_w_ready_i),
        .axi_b_id_i(axi_b_id_i), .axi_b_resp_i(axi_b_resp_i), .axi_b_user_i(axi_b_user_i),
        .axi_b_valid_i(axi_b_valid_i), .axi_b_ready_o(axi_b_ready_o),
        .axi_ar_id_o(axi_ar_id_o), .axi_ar_addr_o(axi_ar_addr_o), .axi_ar_len_o(axi_ar_len_o),
        .axi_ar_size_o(axi_ar_size_o), .axi_ar_burst_o(axi_ar_burst_o), .axi_ar_lock_o(axi_ar_lock_o),
        .axi_ar_cache_o(axi_ar_cache_o), .axi_ar_prot_o(axi_ar_prot_o), .axi_ar_qos_o(axi_ar_qos_o),
        .axi_ar_region_o(axi_ar_region_o), .axi_ar_user_o(axi_ar_user_o),
        .axi_ar_valid_o(axi_ar_valid_o), .axi_ar_ready_i(axi_ar_ready_i),
        .axi_r_id_i(axi_r_id_i), .axi_r_data_i(axi_r_data_i), .axi_r_resp_i(axi_r_resp_i),
        .axi_r_last_i(axi_r_last_i), .axi_r_user_i(axi_r_user_i),
        .axi_r_valid_i(axi_r_valid_i), .axi_r_ready_o(axi_r_ready_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Transaction-level model: one outstanding request, tracked by which
    // handshakes have been seen so far.
    bit            busy, is_wr, aw_seen, w_seen, ar_seen, err_acc;
    bit            pend_done, pend_wr, pend_err;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data, pend_rdata;
    logic [BW-1:0] m_be;
    int            w_beats = 0;
    bit            e_aw, e_w, e_b, e_ar, e_r;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            chk("rst_gnt", gnt_o, 0);
            chk("rst_rvalid", rvalid_o, 0);
            chk("rst_err", err_o, 0);
            chk("rst_rdata", rdata_o, 0);
            chk("rst_valids", {axi_aw_valid_o, axi_w_valid_o, axi_ar_valid_o}, 0);
            chk("rst_readies", {axi_b_ready_o, axi_r_ready_o}, 0);
            chk("rst_attrs", {axi_aw_burst_o, axi_aw_cache_o, axi_aw_size_o, axi_w_last_o,
                              axi_ar_burst_o, axi_ar_cache_o, axi_ar_size_o}, 0);
            chk("rst_addr", {axi_aw_addr_o, axi_w_strb_o}, 0);
            busy = 0; pend_done = 0;
        end else begin
            e_aw = busy && is_wr && !aw_seen;
            e_w  = busy && is_wr && !w_seen;
            e_b  = busy && is_wr && aw_seen && w_seen;
            e_ar = busy && !is_wr && !ar_seen;
            e_r  = busy && !is_wr && ar_seen;
            chk("gnt", gnt_o, req_i && !busy);
            chk("rvalid", rvalid_o, pend_done);
            if (pend_done) begin
                chk("err", err_o, pend_err);
                if (!pend_wr) chk("rdata", rdata_o, pend_rdata);
            end
            chk("aw_valid", axi_aw_valid_o, e_aw);
            chk("w_valid", axi_w_valid_o, e_w);
            chk("b_ready", axi_b_ready_o, e_b);
            chk("ar_valid", axi_ar_valid_o, e_ar);
            chk("r_ready", axi_r_ready_o, e_r);
            if (e_aw) begin
                chk("aw_addr", axi_aw_addr_o, m_addr);
                chk("aw_attr", {axi_aw_len_o, axi_aw_size_o, axi_aw_burst_o, axi_aw_cache_o},
                    {8'd0, 3'd1, BURST_INCR, CACHE_DEFAULT});
                chk("aw_zero", {axi_aw_id_o, axi_aw_user_o, axi_aw_lock_o, axi_aw_prot_o,
                                axi_aw_qos_o, axi_aw_region_o}, 0);
            end
            if (e_w) begin
                chk("w_data", axi_w_data_o, m_data);
                chk("w_strb", axi_w_strb_o, {{(SW-BW){1'b0}}, m_be});
                chk("w_last", axi_w_last_o, 1);
            end
            if (e_ar) begin
                chk("ar_addr", axi_ar_addr_o, m_addr);
                chk("ar_attr", {axi_ar_len_o, axi_ar_size_o, axi_ar_burst_o, axi_ar_cache_o},
                    {8'd0, 3'd1, BURST_INCR, CACHE_DEFAULT});
                chk("ar_zero", {axi_ar_id_o, axi_ar_user_o, axi_ar_lock_o}, 0);
            end
            if (axi_w_valid_o && axi_w_ready_i) w_beats++;
            pend_done = 0;
            if (req_i && !busy) begin
                busy = 1; is_wr = we_i; m_addr = addr_i; m_data = data_i; m_be = be_i;
                aw_seen = 0; w_seen = 0; ar_seen = 0; err_acc = 0;
            end else if (busy) begin
                if (e_aw && axi_aw_ready_i) aw_seen = 1;
                if (e_w && axi_w_ready_i) w_seen = 1;
                if (e_ar && axi_ar_ready_i) ar_seen = 1;
                if (e_b && axi_b_valid_i) begin
                    pend_done = 1; pend_wr = 1; busy = 0;
                    pend_err = ERR_EN && (axi_b_resp_i != RESP_OKAY);
                end
                if (e_r && axi_r_valid_i) begin
                    err_acc = err_acc || (axi_r_resp_i != RESP_OKAY) || !axi_r_last_i;
                    if (axi_r_last_i) begin
                        pend_done = 1; pend_wr = 0; busy = 0;
                        pend_rdata = axi_r_data_i;
                        pend_err = ERR_EN && err_acc;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int gcount;
    int beats0;

    initial begin
        rst_ni = 0; req_i = 0; we_i = 0; addr_i = '0; be_i = '0; data_i = '0;
        axi_aw_ready_i = 0; axi_w_ready_i = 0; axi_ar_ready_i = 0;
        axi_b_valid_i = 0; axi_b_resp_i = 0; axi_b_id_i = '0; axi_b_user_i = '0;
        axi_r_valid_i = 0; axi_r_resp_i = 0; axi_r_last_i = 0; axi_r_data_i = '0;
        axi_r_id_i = '0; axi_r_user_i = '0;
        repeat (3) step();
        rst_ni = 1;
        step();

        // Write, zero wait
        axi_aw_ready_i = 1; axi_w_ready_i = 1; axi_b_valid_i = 1; axi_b_resp_i = RESP_OKAY;
        req_i = 1; we_i = 1; addr_i = 32'h100; be_i = 2'b11; data_i = 16'hBEEF;
        @(negedge clk_i); chk("wr_c0_gnt", gnt_o, 1);
        step(); req_i = 0;
        @(negedge clk_i);
        chk("wr_c1_aw", {axi_aw_valid_o, axi_w_valid_o}, 2'b11);
        chk("wr_c1_addr", axi_aw_addr_o, 32'h100);
        chk("wr_c1_data", axi_w_data_o, 16'hBEEF);
        chk("wr_c1_strb", axi_w_strb_o, 8'h03);
        chk("wr_c1_size_len", {axi_aw_size_o, axi_aw_len_o}, {3'd1, 8'd0});
        step(); @(negedge clk_i); chk("wr_c2_bready", axi_b_ready_o, 1);
        step(); @(negedge clk_i);
        chk("wr_c3_rvalid", rvalid_o, 1);
        chk("wr_c3_err", err_o, 0);
        step(); @(negedge clk_i); chk("wr_c4_rvalid", rvalid_o, 0);
        step();

        // Read, zero wait
        axi_ar_ready_i = 1; axi_r_valid_i = 1; axi_r_data_i = 16'h1234;
        axi_r_resp_i = RESP_OKAY; axi_r_last_i = 1;
        req_i = 1; we_i = 0; addr_i = 32'h200;
        @(negedge clk_i); chk("rd_c0_gnt", gnt_o, 1);
        step(); req_i = 0;
        @(negedge clk_i);
        chk("rd_c1_ar", axi_ar_valid_o, 1);
        chk("rd_c1_addr", axi_ar_addr_o, 32'h200);
        step(); @(negedge clk_i); chk("rd_c2_rready", axi_r_ready_o, 1);
        step(); @(negedge clk_i);
        chk("rd_c3_rvalid", rvalid_o, 1);
        chk("rd_c3_rdata", rdata_o, 16'h1234);
        step(); step();

        // Split write handshake: W at cycle 1, AW at cycle 4
        axi_aw_ready_i = 0; axi_w_ready_i = 1; axi_b_valid_i = 1; axi_b_resp_i = RESP_OKAY;
        req_i = 1; we_i = 1; addr_i = 32'h300; be_i = 2'b01; data_i = 16'hA5A5;
        beats0 = w_beats;
        @(negedge clk_i); chk("sp_c0_gnt", gnt_o, 1);
        step(); req_i = 0;
        @(negedge clk_i); chk("sp_c1_valids", {axi_aw_valid_o, axi_w_valid_o}, 2'b11);
        step(); @(negedge clk_i); chk("sp_c2_valids", {axi_aw_valid_o, axi_w_valid_o}, 2'b10);
        step(); @(negedge clk_i); chk("sp_c3_valids", {axi_aw_valid_o, axi_w_valid_o}, 2'b10);
        step(); axi_aw_ready_i = 1;
        @(negedge clk_i); chk("sp_c4_bready", axi_b_ready_o, 0);
        step(); @(negedge clk_i);
        chk("sp_c5_bready", axi_b_ready_o, 1);
        chk("sp_c5_aw", axi_aw_valid_o, 0);
        step(); @(negedge clk_i);
        chk("sp_c6_rvalid", rvalid_o, 1);
        chk("sp_w_beats", w_beats - beats0, 1);
        step(); step();

        // Error response on B
        axi_b_resp_i = RESP_SLVERR;
        req_i = 1; we_i = 1; addr_i = 32'h310; be_i = 2'b10; data_i = 16'h0001;
        step(); req_i = 0;
        step(); step(); @(negedge clk_i);
        chk("errb_rvalid", rvalid_o, 1);
        chk("errb_err", err_o, ERR_EN);
        step();
        axi_b_resp_i = RESP_OKAY;

        // Error response on R (DECERR)
        axi_r_resp_i = RESP_DECERR; axi_r_data_i = 16'h0BAD;
        req_i = 1; we_i = 0; addr_i = 32'h320;
        step(); req_i = 0;
        step(); step(); @(negedge clk_i);
        chk("errr_rvalid", rvalid_o, 1);
        chk("errr_err", err_o, ERR_EN);
        step(); step();
        axi_r_resp_i = RESP_OKAY;

        // Back-to-back: read then write with req_i held, ar_ready delayed 3 cycles
        axi_ar_ready_i = 0; axi_r_data_i = 16'h5555;
        req_i = 1; we_i = 0; addr_i = 32'h400; data_i = 16'h0F0F; be_i = 2'b11;
        gcount = 0;
        for (int c = 0; c < 10; c++) begin
            if (c == 1) begin we_i = 1; addr_i = 32'h404; end
            if (c == 4) axi_ar_ready_i = 1;
            if (c == 7) req_i = 0;
            @(negedge clk_i);
            if (gnt_o) gcount++;
            if (c == 6) begin
                chk("b2b_c6_gnt", gnt_o, 1);
                chk("b2b_c6_rvalid", rvalid_o, 1);
                chk("b2b_c6_rdata", rdata_o, 16'h5555);
            end
            if (c == 9) chk("b2b_c9_rvalid", rvalid_o, 1);
            step();
        end
        chk("b2b_gnt_count", gcount, 2);
        step();

        // Reset in the middle of a read
        axi_ar_ready_i = 1; axi_r_valid_i = 0; axi_r_data_i = 16'h0040;
        req_i = 1; we_i = 0; addr_i = 32'h500;
        step(); req_i = 0;
        step(); @(negedge clk_i); chk("rr_c2_rready", axi_r_ready_o, 1);
        #2 rst_ni = 0;
        #1;
        chk("rr_async_zero", {axi_ar_valid_o, axi_r_ready_o, rvalid_o}, 3'b000);
        step(); step();
        rst_ni = 1;
        step();
        axi_r_valid_i = 1;
        req_i = 1; we_i = 0; addr_i = 32'h40;
        @(negedge clk_i); chk("rr_new_gnt", gnt_o, 1);
        step(); req_i = 0;
        @(negedge clk_i); chk("rr_new_addr", axi_ar_addr_o, 32'h40);
        step(); step(); @(negedge clk_i);
        chk("rr_new_rvalid", rvalid_o, 1);
        chk("rr_new_rdata", rdata_o, 16'h0040);
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/peripheral_mem2axi4_master.md
# peripheral_mem2axi4_master

Bridge from the simple single-port memory request interface (req/we/addr/be/data) to an AXI4 master port. It is the initiator-side counterpart of the AXI4 SPRAM responder, so a core or DMA engine using the native memory interface can reach any AXI4 slave. Each request becomes one single-beat AXI4 transaction, and only one transaction is outstanding at a time.

## Interface
- AXI_ID_WIDTH, 10, width of the ID fields; this block always drives ID 0.
- AXI_ADDR_WIDTH, 32, address width.
- AXI_DATA_WIDTH, 16, data width; must be a power of two and at least 8.
- AXI_STRB_WIDTH, 8, width of w_strb; must be at least AXI_DATA_WIDTH/8.
- AXI_USER_WIDTH, 10, width of the user fields; this block always drives user 0.
- clk_i  in  1  clock; one clock domain.
- rst_ni  in  1  reset; asynchronous assert, active-low.
- req_i / we_i  in  1 / 1  request valid and write-enable.
- addr_i  in  AXI_ADDR_WIDTH  byte address.
- be_i  in  AXI_DATA_WIDTH/8  byte enables.
- data_i  in  AXI_DATA_WIDTH  write data.
- gnt_o  out  1  request accepted.
- rvalid_o  out  1  one-cycle completion pulse, for reads and for writes.
- rdata_o  out  AXI_DATA_WIDTH  read data; valid while rvalid_o is high.
- err_o  out  1  error flag; valid while rvalid_o is high.
- axi_aw_*, axi_w_*, axi_ar_*  out  standard AXI4 master request channels; the ready inputs are the only inputs on these channels.
- axi_r_*, axi_b_*  in  standard AXI4 response channels; the ready signals are outputs.

## Operation
- States: IDLE, WADDR_DATA, WRESP, RADDR, RDATA.
- **IDLE**
  - gnt_o = req_i, combinational.
  - When req_i is high, addr_i, be_i, data_i and we_i are registered.
  - Next state is WADDR_DATA if we_i is high, otherwise RADDR.
- **WADDR_DATA**
  - aw_valid and w_valid are asserted together.
  - Each valid drops independently after its own handshake; per-channel done flags track this.
  - Once both handshakes have completed → WRESP.
- **WRESP**
  - b_ready = 1.
  - On B handshake: err = (b_resp != OKAY) → IDLE.
- **RADDR**
  - ar_valid is held until ar_ready → RDATA.
- **RDATA**
  - r_ready = 1.
  - On each R handshake: capture r_data, and OR the accumulated error with (r_resp != OKAY) or (r_last == 0).
  - Stay in RDATA until a beat with r_last = 1 → IDLE.
- **Fixed AXI attributes**
  - len = 0, burst = INCR (2'b01), size = log2(AXI_DATA_WIDTH/8).
  - lock = 0, cache = 4'b0011, prot = 3'b000, qos = 0, region = 0.
  - w_last = 1.
- **Width rules**
  - w_strb = be zero-extended to AXI_STRB_WIDTH.
  - The address is passed through unaligned; the AXI slave handles alignment.
- **Boundary conditions**
  - gnt_o is 0 in every state other than IDLE. req_i may stay high across a transaction; it is granted again only on returning to IDLE.
  - aw_ready and w_ready in the same cycle both complete in that cycle.
  - A W handshake before AW, or AW before W, is legal.
  - AXI valid outputs never drop before their handshake.

## Timing
- **Reset values:** every output is 0, including all valids and readies; state is IDLE.
- **Reset mid-transaction:** outputs return to 0 immediately and state returns to IDLE. No completion is reported for the aborted transaction.
- **Valid assertion:** aw/w/ar valid rise in the cycle after gnt_o.
- **Completion:** rvalid_o, rdata_o and err_o are registered. They are valid in the cycle after the final B or R handshake and are held for exactly 1 cycle.
- **Minimum latency, slaves always ready:**
  - write: gnt at cycle 0, AW+W at cycle 1, B at cycle 2, rvalid_o at cycle 3.
  - read: gnt at cycle 0, AR at cycle 1, R at cycle 2, rvalid_o at cycle 3.
- **Back-to-back:** the state is IDLE in the same cycle rvalid_o is high, so the next gnt_o can coincide with rvalid_o.
- **Throughput:** one transaction per 3 cycles at best.

## Configuration
- MEM2AXI4_ERR_EN
  - Defined: err_o reports a SLVERR/DECERR response, or a missing r_last, as described in Operation.
  - Undefined: err_o is tied to 0 and the error-accumulation logic is removed. Response codes are ignored and the state transitions are unchanged.

## Structure
- Shared package peripheral_mem2axi4_pkg contains:
  - the state enum;
  - AXI constants: BURST_INCR, RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR, CACHE_DEFAULT.
- No sub-module. The block is one FSM with a request register, and the per-channel done flags are not worth separating out.

## Test plan
- **Write, zero wait:** req at addr 0x100, be 2'b11, data 0xBEEF; all readies = 1; b_resp = OKAY → aw_addr = 0x100, w_data = 0xBEEF, w_strb = 0x03, size = 1, len = 0; rvalid_o at cycle 3, err_o = 0.
- **Read, zero wait:** req at addr 0x200; R returns 0x1234 with OKAY and last = 1 → rvalid_o at cycle 3, rdata_o = 0x1234.
- **Split write handshake:** w_ready high at cycle 1, aw_ready held low until cycle 4 → w_valid drops after cycle 1; b_ready rises at cycle 5; exactly one W beat is issued.
- **Error response (macro defined):** b_resp = 2'b10 → err_o = 1 with rvalid_o. With the macro undefined, err_o = 0.
- **Back-to-back:** req_i held high for read then write; ar_ready delayed 3 cycles → gnt_o pulses exactly twice; second gnt_o in the same cycle as the first rvalid_o.
- **Reset mid-read:** assert rst_ni low while in RDATA → ar_valid, r_ready and rvalid_o = 0 immediately; after release, a new request at 0x40 completes normally.
